// File: rtl/modulo_step_counter.sv
// Parametrised modulo counter: load / up / down by a variable step, wrap or saturate at the boundaries.
// Optional wrap-event counter enabled by defining MODULO_STEP_COUNTER_WRAPCNT_EN.
module modulo_step_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2**WIDTH,
  parameter int WRAP_W  = 4
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              en,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  d,
  input  logic [WIDTH-1:0]  step,
  input  logic              sat,
  output logic [WIDTH-1:0]  q,
  output logic              at_max,
  output logic              at_min,
  output logic              ovf,
  output logic              load_err,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  // MODULUS itself may be 2**WIDTH, so its low WIDTH bits can be zero; wrapped results
  // always land inside 0..MODULUS-1 and are therefore exact in WIDTH-bit arithmetic.
  localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_LO  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MOD_LO  = WIDTH'(MODULUS);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             ovf_reg, ovf_next;
  logic             load_err_reg, load_err_next;
  logic [WIDTH:0]   step_ext, s_ext, q_ext, sum_ext;
  logic [WIDTH-1:0] s_lo;

  always_comb begin
    step_ext      = {1'b0, step};
    s_ext         = (step_ext > MAX_EXT) ? MAX_EXT : step_ext;
    s_lo          = s_ext[WIDTH-1:0];
    q_ext         = {1'b0, q_reg};
    sum_ext       = q_ext + s_ext;
    q_next        = q_reg;
    ovf_next      = 1'b0;
    load_err_next = 1'b0;
    if (en) begin
      case (op)
        OP_LOAD: begin
          if ({1'b0, d} > MAX_EXT) begin
            q_next        = MAX_LO;
            load_err_next = 1'b1;
          end else begin
            q_next = d;
          end
        end
        OP_UP: begin
          if (sum_ext <= MAX_EXT) begin
            q_next = sum_ext[WIDTH-1:0];
          end else begin
            ovf_next = 1'b1;
            q_next   = sat ? MAX_LO : (sum_ext[WIDTH-1:0] - MOD_LO);
          end
        end
        OP_DOWN: begin
          if (q_ext >= s_ext) begin
            q_next = q_reg - s_lo;
          end else begin
            ovf_next = 1'b1;
            q_next   = sat ? '0 : (q_reg + MOD_LO - s_lo);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      q_reg        <= '0;
      ovf_reg      <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      ovf_reg      <= ovf_next;
      load_err_reg <= load_err_next;
    end
  end

`ifdef MODULO_STEP_COUNTER_WRAPCNT_EN
  logic [WRAP_W-1:0] wrap_cnt_reg;
  logic              wrap_inc;

  // Only genuine modulo wraps count; saturating boundary hits do not.
  assign wrap_inc = ovf_next & ~sat;

  always_ff @(posedge clk) begin
    if (sclr) begin
      wrap_cnt_reg <= '0;
    end else if (wrap_inc && (wrap_cnt_reg != {WRAP_W{1'b1}})) begin
      wrap_cnt_reg <= wrap_cnt_reg + WRAP_W'(1);
    end
  end

  assign wrap_cnt = wrap_cnt_reg;
`else
  assign wrap_cnt = '0;
`endif

  assign q        = q_reg;
  assign ovf      = ovf_reg;
  assign load_err = load_err_reg;
  assign at_max   = (q_reg == MAX_LO);
  assign at_min   = (q_reg == '0);

endmodule
